keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/keypad_scanner_if.sv | 27 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/keypad_scanner.sv | 138 +++++++++++++
 tb/tb_keypad_scanner.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Keypad scanner shared types: FSM state encoding and key_code layout.
// Also holds the small row-priority and code-packing helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    localparam int KC_ROW_MSB = 3;
    localparam int KC_ROW_LSB = 2;
    localparam int KC_COL_MSB = 1;
    localparam int KC_COL_LSB = 0;

    function automatic logic [3:0] pack_code(
        input logic [1:0] row_idx,
        input logic [1:0] col_idx
    );
        logic [3:0] code;
        code = '0;
        code[KC_ROW_MSB:KC_ROW_LSB] = row_idx;
        code[KC_COL_MSB:KC_COL_LSB] = col_idx;
        return code;
    endfunction

    // Rows are active-low; the lowest-index low row wins.
    function automatic logic [1:0] lowest_low(input logic [3:0] row);
        logic [1:0] idx;
        if (!row[0]) begin
            idx = 2'd0;
        end else if (!row[1]) begin
            idx = 2'd1;
        end else if (!row[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines and decoded key outputs.
// master = scanner side, slave = keypad / consumer side.
interface keypad_scanner_if;

    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
// Resets to all-ones so idle (pulled-up) rows read as released.
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with per-tick column scan and
// symmetric press/release debounce; one key_valid per press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_BITS      = 17,
    parameter int DEBOUNCE_TICKS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    keypad_scanner_if.master kp
);

    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0]        DMAX   = DW'(DEBOUNCE_TICKS);
    localparam logic [DW-1:0]        D_ONE  = 1;
    localparam logic [SCAN_BITS-1:0] PS_ONE = 1;

    logic [3:0]           row_s;
    logic [SCAN_BITS-1:0] prescaler_q;
    logic                 tick;

    kp_state_e            state_q, state_d;
    logic [1:0]           col_sel_q, col_sel_d;
    logic [1:0]           row_idx_q, row_idx_d;
    logic [1:0]           col_idx_q, col_idx_d;
    logic [DW-1:0]        deb_cnt_q, deb_cnt_d;
    logic [3:0]           key_code_q, key_code_d;
    logic                 key_valid_q, key_valid_d;

    logic [DW-1:0]        deb_inc;
    logic                 any_low;
    logic                 key_down;

    sync_2ff #(
        .W(4)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (kp.row),
        .q_o  (row_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q <= '0;
        end else begin
            prescaler_q <= prescaler_q + PS_ONE;
        end
    end

    assign tick     = &prescaler_q;
    assign any_low  = ~&row_s;
    assign key_down = ~row_s[row_idx_q];
    assign deb_inc  = (deb_cnt_q == DMAX) ? deb_cnt_q : deb_cnt_q + D_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SCAN;
            col_sel_q   <= '0;
            row_idx_q   <= '0;
            col_idx_q   <= '0;
            deb_cnt_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_sel_q   <= col_sel_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            deb_cnt_q   <= deb_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_sel_d   = col_sel_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        deb_cnt_d   = deb_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;

        if (tick) begin
            unique case (state_q)
                ST_SCAN: begin
                    if (any_low) begin
                        row_idx_d = lowest_low(row_s);
                        col_idx_d = col_sel_q;
                        deb_cnt_d = '0;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        col_sel_d = col_sel_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (key_down) begin
                        deb_cnt_d = deb_inc;
                        if (deb_inc == DMAX) begin
                            state_d     = ST_HELD;
                            key_code_d  = pack_code(row_idx_q, col_idx_q);
                            key_valid_d = 1'b1;
                        end
                    end else begin
                        state_d   = ST_SCAN;
                        col_sel_d = col_sel_q + 2'd1;
                    end
                end
                ST_HELD: begin
                    if (!key_down) begin
                        deb_cnt_d = '0;
                        state_d   = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!key_down) begin
                        deb_cnt_d = deb_inc;
                        if (deb_inc == DMAX) begin
                            state_d   = ST_SCAN;
                            col_sel_d = col_sel_q + 2'd1;
                        end
                    end else begin
                        state_d = ST_HELD;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    assign kp.col       = ~(4'b0001 << col_sel_q);
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = (state_q == ST_HELD) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized + directed bench for keypad_scanner against a
// tick-level key-matrix reference model.
module tb_keypad_scanner;

    localparam int SB  = 4;
    localparam int DT  = 3;
    localparam int PER = 1 << SB;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_BITS     (SB),
        .DEBOUNCE_TICKS(DT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kp   (kif)
    );

    // pk[r][c] = 1 means the key at row r, column c is pressed
    logic [3:0] pk [4];

    always_comb begin
        kif.row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            kif.row[r] = ~|(pk[r] & ~kif.col);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int m_pulses = 0;
    int d_pulses = 0;

    int         m_col, m_r, m_c, m_run, m_hi;
    bit         m_have, m_acc, m_valid;
    logic [3:0] m_code;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_col   = 0;
        m_have  = 0;
        m_acc   = 0;
        m_run   = 0;
        m_hi    = 0;
        m_code  = 4'h0;
        m_valid = 0;
    endtask

    // One scan tick: find a candidate, count steady ticks, accept, release.
    task automatic model_tick();
        int found;
        if (!m_have) begin
            found = -1;
            for (int r = 3; r >= 0; r--)
                if (pk[r][m_col]) found = r;
            if (found >= 0) begin
                m_have = 1;
                m_r    = found;
                m_c    = m_col;
                m_run  = 0;
            end else begin
                m_col = (m_col + 1) % 4;
            end
        end else if (!m_acc) begin
            if (pk[m_r][m_c]) begin
                m_run++;
                if (m_run == DT) begin
                    m_acc   = 1;
                    m_hi    = 0;
                    m_code  = 4'(m_r * 4 + m_c);
                    m_valid = 1;
                    m_pulses++;
                end
            end else begin
                m_have = 0;
                m_col  = (m_col + 1) % 4;
            end
        end else begin
            if (!pk[m_r][m_c]) begin
                m_hi++;
                if (m_hi == DT + 1) begin
                    m_have = 0;
                    m_acc  = 0;
                    m_col  = (m_col + 1) % 4;
                end
            end else begin
                m_hi = 0;
            end
        end
    endtask

    task automatic step();
        logic [3:0] ecol;
        bit tk;
        @(posedge clk);
        tk = (cyc % PER) == PER - 1;
        cyc++;
        m_valid = 0;
        if (tk) model_tick();
        @(negedge clk);
        if (kif.key_valid === 1'b1) d_pulses++;
        ecol = ~(4'b0001 << m_col);
        chk("col", kif.col, ecol);
        chk("held", kif.key_held, m_acc);
        chk("valid", kif.key_valid, m_valid);
        chk("code", kif.key_code, m_code);
    endtask

    task automatic run_ticks(input int n);
        repeat (n) repeat (PER) step();
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++) pk[r] = 4'h0;
    endtask

    task automatic goto_col(input int c);
        logic [3:0] e;
        for (int i = 0; i < 8 && m_col != c; i++) run_ticks(1);
        e = ~(4'b0001 << c);
        chk("goto_col", kif.col, e);
    endtask

    // Called right after a step, i.e. just past a falling edge.
    task automatic hit_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_col", kif.col, 4'hE);
        chk("arst_held", kif.key_held, 1'b0);
        chk("arst_valid", kif.key_valid, 1'b0);
        chk("arst_code", kif.key_code, 4'h0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        int v0;
        clear_keys();
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_col", kif.col, 4'hE);
        chk("rst_held", kif.key_held, 1'b0);
        chk("rst_valid", kif.key_valid, 1'b0);
        chk("rst_code", kif.key_code, 4'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        // idle column walk
        run_ticks(5);

        // row2 in col1: accept, then hold
        goto_col(1);
        v0 = d_pulses;
        pk[2][1] = 1'b1;
        run_ticks(5);
        chk("p1_pulses", d_pulses - v0, 1);
        chk("p1_code", kif.key_code, 4'b1001);
        chk("p1_held", kif.key_held, 1'b1);
        chk("p1_col", kif.col, 4'b1101);

        // bounce on release, re-press, full release
        pk[2][1] = 1'b0;
        run_ticks(2);
        chk("bounce_held", kif.key_held, 1'b1);
        pk[2][1] = 1'b1;
        run_ticks(2);
        chk("repress_held", kif.key_held, 1'b1);
        pk[2][1] = 1'b0;
        run_ticks(4);
        chk("rel_held", kif.key_held, 1'b0);
        chk("rel_col", kif.col, 4'b1011);
        chk("rel_pulses", d_pulses - v0, 1);

        // one-tick glitch on row0/col0
        goto_col(0);
        v0 = d_pulses;
        pk[0][0] = 1'b1;
        run_ticks(1);
        pk[0][0] = 1'b0;
        run_ticks(1);
        chk("glitch_col", kif.col, 4'b1101);
        run_ticks(2);
        chk("glitch_pulses", d_pulses - v0, 0);

        // rows 1 and 3 in col3
        goto_col(3);
        pk[1][3] = 1'b1;
        pk[3][3] = 1'b1;
        run_ticks(5);
        chk("multi_code", kif.key_code, 4'b0111);
        chk("multi_held", kif.key_held, 1'b1);
        pk[1][3] = 1'b0;
        run_ticks(6);
        clear_keys();
        run_ticks(2);

        // reset while held, key stays down
        goto_col(1);
        pk[2][1] = 1'b1;
        run_ticks(5);
        chk("pre_rst_held", kif.key_held, 1'b1);
        v0 = d_pulses;
        hit_reset();
        run_ticks(6);
        chk("post_rst_pulses", d_pulses - v0, 1);
        chk("post_rst_code", kif.key_code, 4'b1001);
        clear_keys();
        run_ticks(6);

        // reset during debounce
        goto_col(1);
        pk[2][1] = 1'b1;
        run_ticks(2);
        v0 = d_pulses;
        hit_reset();
        chk("deb_rst_pulses", d_pulses - v0, 0);
        clear_keys();
        run_ticks(2);

        for (int e = 0; e < 50; e++) begin
            int k;
            clear_keys();
            k = $urandom_range(0, 3);
            repeat (k) pk[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
            if ($urandom_range(0, 11) == 0) hit_reset();
            run_ticks($urandom_range(1, 7));
        end

        clear_keys();
        run_ticks(6);
        chk("total_pulses", d_pulses, m_pulses);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
